// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// rr_pick returns the one-hot winner found by scanning req circularly from ptr.
package arb_pkg;

   localparam int ARB_N     = 8;
   localparam int ARB_IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   function automatic logic [ARB_N-1:0] rr_pick(input logic [ARB_N-1:0]     req,
                                                input logic [ARB_IDX_W-1:0] ptr);
      logic [ARB_N-1:0]     win;
      logic                 found;
      logic [ARB_IDX_W-1:0] pos;
      win   = '0;
      found = 1'b0;
      // Position arithmetic wraps naturally in ARB_IDX_W bits, giving the circular scan.
      for (int i = 0; i < ARB_N; i++) begin
         pos = ptr + ARB_IDX_W'(i);
         if (!found && req[pos]) begin
            win[pos] = 1'b1;
            found    = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/onehot_enc8x3.sv
// Combinational 8-to-3 one-hot encoder; each index bit is the OR of the
// one-hot lines whose position has that bit set. All-zero input encodes to 0.
module onehot_enc8x3
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0]     onehot_i,
   output logic [ARB_IDX_W-1:0] idx_o
);

   assign idx_o[0] = onehot_i[1] | onehot_i[3] | onehot_i[5] | onehot_i[7];
   assign idx_o[1] = onehot_i[2] | onehot_i[3] | onehot_i[6] | onehot_i[7];
   assign idx_o[2] = onehot_i[4] | onehot_i[5] | onehot_i[6] | onehot_i[7];

endmodule

// File: rtl/rr_arbiter_8.sv
// Non-preemptive round-robin arbiter for 8 requesters with a registered one-hot grant.
// Define ARB_TIMEOUT_EN to build the hold counter that force-revokes a grant after MAX_HOLD cycles.
module rr_arbiter_8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ARB_N-1:0]     req,
   output logic [ARB_N-1:0]     gnt,
   output logic [ARB_IDX_W-1:0] gnt_idx,
   output logic                 gnt_valid,
   output logic                 timeout
);

   if (MAX_HOLD < 1 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
      $error("rr_arbiter_8: MAX_HOLD must be in 1..2**CNT_W-1");
   end

   arb_state_e           state_q, state_d;
   logic [ARB_N-1:0]     gnt_q, gnt_d;
   logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
   logic [ARB_IDX_W-1:0] idx;

   onehot_enc8x3 u_enc (
      .onehot_i (gnt_q),
      .idx_o    (idx)
   );

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             timeout_q, timeout_d;
   logic             hold_expired;

   assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
   // Counter is zero on the first GRANT cycle because every IDLE cycle clears it.
   assign hold_cnt_d   = (state_q == ST_GRANT) ? hold_cnt_q + CNT_W'(1) : '0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d   = rr_pick(req, ptr_q);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // Voluntary release is checked first so it wins over a simultaneous timeout.
            if (!req[idx]) begin
               gnt_d   = '0;
               ptr_d   = idx + ARB_IDX_W'(1);
               state_d = ST_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_expired) begin
               gnt_d     = '0;
               ptr_d     = idx + ARB_IDX_W'(1);
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
`endif
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign gnt       = gnt_q;
   assign gnt_idx   = idx;
   assign gnt_valid = |gnt_q;

   a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

endmodule
